aes_subbytes_seq: RTL

//  Byte-serial SubBytes sequencer around the masked (DOM) aes_sbox.
//  - Latches a 128-bit state in SHARES Boolean shares.
//  - Feeds one shared byte per cycle into the pipelined sbox.
//  - Collects each sbox result SBOX_LATENCY cycles later into an output state register.
//  - Sits between the round-state register and aes_sbox; drives the sbox input and consumes its output.
//  - Fresh randomness (Z*, B*) is supplied to the sbox externally. This block only flags the cycles that consume it.

---
 rtl/aes_subbytes_seq_pkg.sv | 23 ++
 rtl/aes_subbytes_seq_if.sv | 36 +++
 rtl/aes_subbytes_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/aes_subbytes_seq_pkg.sv
// ---------------------------------------------------------------------------
// aes_subbytes_seq_pkg
//   Shared constants and types for the byte-serial AES sequencers.
//   NUM_BYTES  : bytes per 128-bit AES state
//   state_e    : sequencer FSM encoding (IDLE / RUN / DONE)
//   byte_lsb() : bit offset of byte b of share s in a shared state vector
// ---------------------------------------------------------------------------
package aes_subbytes_seq_pkg;

    localparam int NUM_BYTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Share s occupies 128 bits; byte b sits at 8*b inside its share.
    function automatic int byte_lsb(input int s, input int b);
        return s * 128 + 8 * b;
    endfunction

endpackage

// File: rtl/aes_subbytes_seq_if.sv
// ---------------------------------------------------------------------------
// aes_subbytes_seq_if
//   Bundle between the round logic / masked sbox and the SubBytes sequencer.
//   StartxSI    start request (sampled by the sequencer only when idle)
//   StatexDI    input state, SHARES x 128 bits
//   SboxInxDO   one shared byte to the sbox, SHARES x 8 bits
//   SboxOutxDI  shared byte from the sbox, same packing
//   RndReqxSO   high on cycles a byte enters the sbox
//   StatexDO    SubBytes result, SHARES x 128 bits
//   BusyxSO     sequencer running
//   DonexSO     one-cycle completion pulse
//   master : the surrounding datapath (drives start/state/sbox result)
//   slave  : the sequencer
// ---------------------------------------------------------------------------
interface aes_subbytes_seq_if #(
    parameter int SHARES = 2
);
    logic                    StartxSI;
    logic [128*SHARES-1:0]   StatexDI;
    logic [8*SHARES-1:0]     SboxInxDO;
    logic [8*SHARES-1:0]     SboxOutxDI;
    logic                    RndReqxSO;
    logic [128*SHARES-1:0]   StatexDO;
    logic                    BusyxSO;
    logic                    DonexSO;

    modport master (
        output StartxSI, StatexDI, SboxOutxDI,
        input  SboxInxDO, RndReqxSO, StatexDO, BusyxSO, DonexSO
    );

    modport slave (
        input  StartxSI, StatexDI, SboxOutxDI,
        output SboxInxDO, RndReqxSO, StatexDO, BusyxSO, DonexSO
    );
endinterface

// File: rtl/aes_subbytes_seq.sv
// ---------------------------------------------------------------------------
// aes_subbytes_seq
//   Byte-serial SubBytes sequencer in front of a pipelined masked (DOM)
//   sbox. A shared 128-bit state is latched on start, one shared byte per
//   cycle is fed to the sbox, and each sbox result is written back into the
//   output state SBOX_LATENCY cycles later. Shares are never recombined.
//
//   Parameters
//     SHARES        number of Boolean shares (>=2)
//     SBOX_LATENCY  sbox input-to-output latency in cycles (>=1)
//   Ports
//     ClkxCI   clock, rising edge
//     RstxBI   synchronous active-low reset
//     bus      aes_subbytes_seq_if slave modport (see interface header)
// ---------------------------------------------------------------------------
module aes_subbytes_seq
    import aes_subbytes_seq_pkg::*;
#(
    parameter int SHARES       = 2,
    parameter int SBOX_LATENCY = 4
) (
    input  logic              ClkxCI,
    input  logic              RstxBI,
    aes_subbytes_seq_if.slave bus
);

    localparam int CNT_W = $clog2(NUM_BYTES + SBOX_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1 + SBOX_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAT  = CNT_W'(SBOX_LATENCY);
    localparam logic [CNT_W-1:0] CNT_FEED = CNT_W'(NUM_BYTES - 1);

    state_e                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [128*SHARES-1:0]  r_state_in;
    logic [128*SHARES-1:0]  r_state_out;
    logic [8*SHARES-1:0]    r_sbox_in;
    logic                   r_rnd_req;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_start;
    logic                   w_feed_nxt;
    logic [3:0]             w_feed_idx;
    logic [128*SHARES-1:0]  w_feed_src;
    logic [8*SHARES-1:0]    w_feed_byte;
    logic                   w_cap_en;
    logic [3:0]             w_cap_idx;
    logic [NUM_BYTES-1:0]   w_byte_we;

    assign w_start = (r_state == ST_IDLE) && bus.StartxSI;

    // The sbox input register is loaded one cycle ahead: at the start edge
    // with byte 0 straight from StatexDI (the latch happens on that same
    // edge), then with byte cnt+1 from the latched copy while bytes remain.
    always_comb begin
        w_feed_nxt = 1'b0;
        w_feed_idx = 4'd0;
        w_feed_src = r_state_in;
        if (w_start) begin
            w_feed_nxt = 1'b1;
            w_feed_src = bus.StatexDI;
        end else if ((r_state == ST_RUN) && (r_cnt < CNT_FEED)) begin
            w_feed_nxt = 1'b1;
            w_feed_idx = 4'(r_cnt + 1'b1);
        end
    end

    for (genvar s = 0; s < SHARES; s++) begin : g_feed_mux
        assign w_feed_byte[s*8 +: 8] = w_feed_src[s*128 + 8*int'(w_feed_idx) +: 8];
    end

    // Result of byte cnt-SBOX_LATENCY is on SboxOutxDI this cycle.
    assign w_cap_en  = (r_state == ST_RUN) && (r_cnt >= CNT_LAT);
    assign w_cap_idx = 4'(r_cnt - CNT_LAT);

    for (genvar b = 0; b < NUM_BYTES; b++) begin : g_cap_demux
        assign w_byte_we[b] = w_cap_en && (w_cap_idx == 4'(b));
    end

    always_ff @(posedge ClkxCI) begin
        if (!RstxBI) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_state_in  <= '0;
            r_state_out <= '0;
            r_sbox_in   <= '0;
            r_rnd_req   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.StartxSI) begin
                        r_state    <= ST_RUN;
                        r_cnt      <= '0;
                        r_state_in <= bus.StatexDI;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_DONE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase

            // Idle cycles drive zeros so no stale share reaches the sbox.
            r_sbox_in <= w_feed_nxt ? w_feed_byte : '0;
            r_rnd_req <= w_feed_nxt;

            for (int s = 0; s < SHARES; s++) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (w_byte_we[b]) begin
                        r_state_out[byte_lsb(s, b) +: 8] <= bus.SboxOutxDI[s*8 +: 8];
                    end
                end
            end
        end
    end

    assign bus.SboxInxDO = r_sbox_in;
    assign bus.RndReqxSO = r_rnd_req;
    assign bus.StatexDO  = r_state_out;
    assign bus.BusyxSO   = r_busy;
    assign bus.DonexSO   = r_done;

endmodule
